// File: rtl/ahb_lite_master.sv
// AHB-Lite single-channel master.
// Bridges a valid/ready load-store request port onto AHB-Lite using SINGLE
// transfers with address/data-phase pipelining, so zero-wait slaves see one
// transfer per cycle. Responses come back in request order, one cycle after
// the data phase completes.
// Optional build macro: AHB_MST_TIMEOUT_EN enables the sticky wait-state
// timeout flag. When it is undefined, timeout is tied low.
module ahb_lite_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [2:0]            req_size,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] HADDR,
   output logic [1:0]            HTRANS,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic                  HMASTLOCK,
   output logic [DATA_WIDTH-1:0] HWDATA,
   input  logic [DATA_WIDTH-1:0] HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP,
   output logic                  timeout
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   logic                  a_valid;
   logic [DATA_WIDTH-1:0] a_wdata;
   logic                  d_valid;
   logic                  d_write;
   logic                  aligned;
   logic                  accept;
   logic                  acc_al;
   logic                  acc_mis;

   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;

   // Natural alignment check; sizes above word are never legal on this bus.
   always_comb begin
      aligned = 1'b0;
      case (req_size)
         3'd0:    aligned = 1'b1;
         3'd1:    aligned = ~req_addr[0];
         3'd2:    aligned = (req_addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   // Misaligned requests wait for an empty pipeline so their local error
   // response can never land in the same cycle as a bus response.
   always_comb begin
      if (aligned) req_ready = HREADY;
      else         req_ready = HREADY & ~a_valid & ~d_valid;
   end

   assign accept  = req_valid & req_ready;
   assign acc_al  = accept & aligned;
   assign acc_mis = accept & ~aligned;

   // Address and data stage registers; everything freezes while HREADY is low.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_valid <= 1'b0;
         a_wdata <= '0;
         d_valid <= 1'b0;
         d_write <= 1'b0;
         HADDR   <= '0;
         HTRANS  <= TRANS_IDLE;
         HWRITE  <= 1'b0;
         HSIZE   <= 3'b000;
         HWDATA  <= '0;
      end else if (HREADY) begin
         d_valid <= a_valid;
         d_write <= HWRITE;
         HWDATA  <= a_wdata;
         if (acc_al) begin
            HADDR   <= req_addr;
            HWRITE  <= req_write;
            HSIZE   <= req_size;
            HTRANS  <= TRANS_NONSEQ;
            a_valid <= 1'b1;
            a_wdata <= req_wdata;
         end else begin
            HTRANS  <= TRANS_IDLE;
            a_valid <= 1'b0;
         end
      end
   end

   // Response port: bus completion, or immediate error for a misaligned accept.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else if (HREADY && d_valid) begin
         rsp_valid <= 1'b1;
         rsp_err   <= HRESP;
         rsp_rdata <= (!d_write && !HRESP) ? HRDATA : '0;
      end else if (acc_mis) begin
         rsp_valid <= 1'b1;
         rsp_err   <= 1'b1;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end
   end

`ifdef AHB_MST_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt;

   // Counts consecutive stalled data-phase cycles; the flag is sticky and the
   // transfer itself is left running.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         to_cnt  <= '0;
         timeout <= 1'b0;
      end else if (HREADY) begin
         to_cnt <= '0;
      end else if (d_valid) begin
         if (to_cnt != TO_W'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + TO_W'(1);
         if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed testbench for ahb_lite_master with hand-computed expectations.
module tb_ahb_lite_master;

   logic        HCLK;
   logic        HRESETn;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [2:0]  req_size;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;
   logic        timeout;

   int n_chk;
   int n_err;

   ahb_lite_master #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HBURST    (HBURST),
      .HPROT     (HPROT),
      .HMASTLOCK (HMASTLOCK),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .HREADY    (HREADY),
      .HRESP     (HRESP),
      .timeout   (timeout)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc_end();
      @(posedge HCLK);
      #1;
   endtask

   task automatic req(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_size  = s;
      req_wdata = d;
   endtask

   task automatic no_req();
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'h0;
      req_size  = 3'd0;
      req_wdata = 32'h0;
   endtask

   task automatic bus(input logic rdy, input logic rsp, input logic [31:0] rd);
      HREADY = rdy;
      HRESP  = rsp;
      HRDATA = rd;
   endtask

   function automatic logic [31:0] pat(input int i);
      return 32'hC0DE_0000 + 32'(i) * 32'h11;
   endfunction

   initial begin
      n_chk   = 0;
      n_err   = 0;
      HRESETn = 1'b0;
      no_req();
      bus(1'b1, 1'b0, 32'h0);

      // reset values
      #12;
      chk("rst_htrans", 32'(HTRANS), 32'h0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwrite", 32'(HWRITE), 32'h0);
      chk("rst_hsize", 32'(HSIZE), 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_rspv", 32'(rsp_valid), 32'h0);
      chk("rst_rsperr", 32'(rsp_err), 32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      chk("const_hburst", 32'(HBURST), 32'h0);
      chk("const_hprot", 32'(HPROT), 32'h3);
      chk("const_lock", 32'(HMASTLOCK), 32'h0);
      #10;
      HRESETn = 1'b1;
      cyc_end();

      // single word write
      req(1'b1, 32'h100, 3'd2, 32'hDEADBEEF);
      @(negedge HCLK);
      chk("t1_ready", 32'(req_ready), 32'h1);
      cyc_end();
      no_req();
      @(negedge HCLK);
      chk("t1_htrans", 32'(HTRANS), 32'h2);
      chk("t1_haddr", HADDR, 32'h100);
      chk("t1_hwrite", 32'(HWRITE), 32'h1);
      chk("t1_hsize", 32'(HSIZE), 32'h2);
      chk("t1_rspv_c1", 32'(rsp_valid), 32'h0);
      cyc_end();
      @(negedge HCLK);
      chk("t1_htrans_c2", 32'(HTRANS), 32'h0);
      chk("t1_hwdata", HWDATA, 32'hDEADBEEF);
      chk("t1_rspv_c2", 32'(rsp_valid), 32'h0);
      cyc_end();
      @(negedge HCLK);
      chk("t1_rspv_c3", 32'(rsp_valid), 32'h1);
      chk("t1_rsperr", 32'(rsp_err), 32'h0);
      chk("t1_rdata", rsp_rdata, 32'h0);
      cyc_end();
      @(negedge HCLK);
      chk("t1_rspv_c4", 32'(rsp_valid), 32'h0);
      cyc_end();

      // four back-to-back reads, zero wait
      for (int c = 0; c < 8; c++) begin
         if (c < 4) req(1'b0, 32'(4 * c), 3'd2, 32'h0);
         else       no_req();
         bus(1'b1, 1'b0, (c >= 2 && c <= 5) ? pat(c - 2) : 32'h0);
         @(negedge HCLK);
         chk("t2_htrans", 32'(HTRANS), (c >= 1 && c <= 4) ? 32'h2 : 32'h0);
         if (c >= 1 && c <= 4) chk("t2_haddr", HADDR, 32'(4 * (c - 1)));
         chk("t2_rspv", 32'(rsp_valid), (c >= 3 && c <= 6) ? 32'h1 : 32'h0);
         if (c >= 3 && c <= 6) chk("t2_rdata", rsp_rdata, pat(c - 3));
         cyc_end();
      end

      // read 0x20 with three wait states, read 0x24 pipelined behind it
      for (int c = 0; c < 9; c++) begin
         case (c)
            0:       begin req(1'b0, 32'h20, 3'd2, 32'h0); bus(1'b1, 1'b0, 32'h0); end
            1:       begin req(1'b0, 32'h24, 3'd2, 32'h0); bus(1'b1, 1'b0, 32'h0); end
            2, 3, 4: begin req(1'b0, 32'h28, 3'd2, 32'h0); bus(1'b0, 1'b0, 32'h0); end
            5:       begin no_req(); bus(1'b1, 1'b0, 32'h20202020); end
            6:       begin no_req(); bus(1'b1, 1'b0, 32'h24242424); end
            default: begin no_req(); bus(1'b1, 1'b0, 32'h0); end
         endcase
         @(negedge HCLK);
         if (c == 1) chk("t3_haddr_a", HADDR, 32'h20);
         if (c >= 2 && c <= 4) chk("t3_ready_wait", 32'(req_ready), 32'h0);
         if (c >= 2 && c <= 5) begin
            chk("t3_htrans_hold", 32'(HTRANS), 32'h2);
            chk("t3_haddr_hold", HADDR, 32'h24);
         end
         if (c == 6) chk("t3_htrans_idle", 32'(HTRANS), 32'h0);
         chk("t3_rspv", 32'(rsp_valid), (c == 6 || c == 7) ? 32'h1 : 32'h0);
         if (c == 6) chk("t3_rdata_a", rsp_rdata, 32'h20202020);
         if (c == 7) chk("t3_rdata_b", rsp_rdata, 32'h24242424);
         cyc_end();
      end

      // two-cycle ERROR on a read, pipelined write completes normally
      for (int c = 0; c < 7; c++) begin
         case (c)
            0:       begin req(1'b0, 32'h40, 3'd2, 32'h0); bus(1'b1, 1'b0, 32'h0); end
            1:       begin req(1'b1, 32'h44, 3'd2, 32'h5555AAAA); bus(1'b1, 1'b0, 32'h0); end
            2:       begin no_req(); bus(1'b0, 1'b1, 32'hFFFFFFFF); end
            3:       begin no_req(); bus(1'b1, 1'b1, 32'hFFFFFFFF); end
            default: begin no_req(); bus(1'b1, 1'b0, 32'h0); end
         endcase
         @(negedge HCLK);
         if (c == 3) begin
            chk("t4_htrans_kept", 32'(HTRANS), 32'h2);
            chk("t4_haddr_kept", HADDR, 32'h44);
            chk("t4_hwrite_kept", 32'(HWRITE), 32'h1);
         end
         if (c == 4) begin
            chk("t4_err_rsperr", 32'(rsp_err), 32'h1);
            chk("t4_err_rdata", rsp_rdata, 32'h0);
            chk("t4_hwdata", HWDATA, 32'h5555AAAA);
            chk("t4_htrans_idle", 32'(HTRANS), 32'h0);
         end
         if (c == 5) chk("t4_wr_rsperr", 32'(rsp_err), 32'h0);
         chk("t4_rspv", 32'(rsp_valid), (c == 4 || c == 5) ? 32'h1 : 32'h0);
         cyc_end();
      end

      // misaligned half-word held off until the pipeline drains
      for (int c = 0; c < 6; c++) begin
         case (c)
            0:       begin req(1'b0, 32'h80, 3'd2, 32'h0); bus(1'b1, 1'b0, 32'h0); end
            1, 3:    begin req(1'b0, 32'h103, 3'd1, 32'h0); bus(1'b1, 1'b0, 32'h0); end
            2:       begin req(1'b0, 32'h103, 3'd1, 32'h0); bus(1'b1, 1'b0, 32'h8080); end
            default: begin no_req(); bus(1'b1, 1'b0, 32'h0); end
         endcase
         @(negedge HCLK);
         if (c == 1) chk("t5_ready_c1", 32'(req_ready), 32'h0);
         if (c == 2) chk("t5_ready_c2", 32'(req_ready), 32'h0);
         if (c == 3) begin
            chk("t5_ready_c3", 32'(req_ready), 32'h1);
            chk("t5_rd_rdata", rsp_rdata, 32'h8080);
            chk("t5_rd_rsperr", 32'(rsp_err), 32'h0);
         end
         if (c == 4) begin
            chk("t5_mis_rsperr", 32'(rsp_err), 32'h1);
            chk("t5_mis_rdata", rsp_rdata, 32'h0);
         end
         chk("t5_htrans", 32'(HTRANS), (c == 1) ? 32'h2 : 32'h0);
         chk("t5_rspv", 32'(rsp_valid), (c == 3 || c == 4) ? 32'h1 : 32'h0);
         cyc_end();
      end

      // illegal size code on an idle bus is rejected immediately
      req(1'b0, 32'h0, 3'd4, 32'h0);
      bus(1'b1, 1'b0, 32'h0);
      @(negedge HCLK);
      chk("t6_ready", 32'(req_ready), 32'h1);
      cyc_end();
      no_req();
      @(negedge HCLK);
      chk("t6_htrans", 32'(HTRANS), 32'h0);
      chk("t6_rspv", 32'(rsp_valid), 32'h1);
      chk("t6_rsperr", 32'(rsp_err), 32'h1);
      cyc_end();

      // long stall: ten wait states in the data phase
      for (int c = 0; c < 14; c++) begin
         if (c == 0) req(1'b0, 32'h200, 3'd2, 32'h0);
         else        no_req();
         if (c >= 2 && c <= 11) bus(1'b0, 1'b0, 32'h0);
         else if (c == 12)      bus(1'b1, 1'b0, 32'h12345678);
         else                   bus(1'b1, 1'b0, 32'h0);
         @(negedge HCLK);
`ifdef AHB_MST_TIMEOUT_EN
         if (c == 9)  chk("t7_timeout_c9", 32'(timeout), 32'h0);
         if (c == 10) chk("t7_timeout_c10", 32'(timeout), 32'h1);
         if (c == 13) chk("t7_timeout_sticky", 32'(timeout), 32'h1);
`else
         if (c == 10 || c == 13) chk("t7_timeout_off", 32'(timeout), 32'h0);
`endif
         chk("t7_rspv", 32'(rsp_valid), (c == 13) ? 32'h1 : 32'h0);
         if (c == 13) chk("t7_rdata", rsp_rdata, 32'h12345678);
         cyc_end();
      end

      // reset in the middle of a transfer drops it without a response
      req(1'b0, 32'h300, 3'd2, 32'h0);
      bus(1'b1, 1'b0, 32'h0);
      cyc_end();
      no_req();
      @(negedge HCLK);
      chk("t8_htrans_pre", 32'(HTRANS), 32'h2);
      HRESETn = 1'b0;
      #1;
      chk("t8_htrans_rst", 32'(HTRANS), 32'h0);
      chk("t8_haddr_rst", HADDR, 32'h0);
      cyc_end();
      HRESETn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge HCLK);
         chk("t8_rspv_after", 32'(rsp_valid), 32'h0);
         chk("t8_timeout_after", 32'(timeout), 32'h0);
         cyc_end();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
